// File: rtl/esm_pkg.sv
// Shared definitions for the ESM fetch feeder: opcodes, FIFO entry type and the
// RegWrite/ALUSrc decode helper.
package esm_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [INSTR_W-1:0] NOP_WORD = '0;

    // Only the raw word is buffered; flags are decoded when the entry is popped.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        logic reg_write;
        logic alu_src;
    } dec_flags_t;

    function automatic dec_flags_t decode(input logic [6:0] opcode);
        dec_flags_t f;
        f = '0;
        case (opcode)
            OP_R, OP_JAL: begin
                f.reg_write = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JALR: begin
                f.reg_write = 1'b1;
                f.alu_src   = 1'b1;
            end
            OP_STORE: begin
                f.alu_src = 1'b1;
            end
            default: begin
                f = '0;
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/esm_fetch_fifo.sv
// Prefetch FIFO for the fetch feeder: synchronous push/pop/clear, async reset,
// simultaneous push and pop allowed even when full.
module esm_fetch_fifo
    import esm_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    fetch_entry_t     mem_q [FIFO_DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push is about to use.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/esm_fetch_feeder.sv
// Instruction fetch stage feeding ESM: credit-limited in-order fetch, prefetch FIFO,
// registered Instr_out/RegWrite/ALUSrc. ESM_FETCH_PERF_EN adds a bubble counter.
module esm_fetch_feeder
    import esm_pkg::*;
#(
    parameter int unsigned       Instruction_word_size = INSTR_W,
    parameter int unsigned       FIFO_DEPTH            = 4,
    parameter int unsigned       ADDR_W                = 32,
    parameter logic [ADDR_W-1:0] RESET_PC              = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             imem_req,
    output logic [ADDR_W-1:0]                imem_addr,
    input  logic                             imem_valid,
    input  logic [Instruction_word_size-1:0] imem_rdata,
    input  logic                             stall,
    input  logic                             flush,
    input  logic [ADDR_W-1:0]                flush_pc,
    output logic [Instruction_word_size-1:0] Instr_out,
    output logic                             RegWrite,
    output logic                             ALUSrc
`ifdef ESM_FETCH_PERF_EN
    ,
    output logic [31:0]                      bubble_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    logic [Instruction_word_size-1:0] instr_q;
    logic                             reg_write_q;
    logic                             alu_src_q;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_wdata;
    fetch_entry_t     fifo_rdata;

    logic                             resp;
    logic                             credit_ok;
    logic [Instruction_word_size-1:0] head_instr;
    dec_flags_t                       head_flags;

    esm_fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (flush),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // A response with nothing outstanding can only be a stray from before a reset.
    assign resp      = imem_valid && (outst_q != '0);
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, outst_q}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign imem_req  = !rst && !flush && credit_ok;
    assign imem_addr = pc_q;

    assign fifo_wdata.instr = INSTR_W'(imem_rdata);
    assign head_instr       = Instruction_word_size'(fifo_rdata.instr);
    assign head_flags       = decode(head_instr[6:0]);

    always_comb begin
        pc_d      = pc_q;
        outst_d   = outst_q;
        drop_d    = drop_q;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (flush) begin
            pc_d    = flush_pc;
            outst_d = outst_q - CNT_W'(resp);
            // Everything still in flight after this cycle belongs to the old stream.
            drop_d  = outst_d;
        end else begin
            if (imem_req) begin
                pc_d = pc_q + ADDR_W'(4);
            end
            outst_d = outst_q + CNT_W'(imem_req) - CNT_W'(resp);
            if (resp) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CNT_W'(1);
                end else begin
                    fifo_push = 1'b1;
                end
            end
            fifo_pop = !stall && !fifo_empty;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q     <= '0;
            reg_write_q <= 1'b0;
            alu_src_q   <= 1'b0;
        end else if (flush) begin
            instr_q     <= '0;
            reg_write_q <= 1'b0;
            alu_src_q   <= 1'b0;
        end else if (!stall) begin
            if (!fifo_empty) begin
                instr_q     <= head_instr;
                reg_write_q <= head_flags.reg_write;
                alu_src_q   <= head_flags.alu_src;
            end else begin
                instr_q     <= Instruction_word_size'(NOP_WORD);
                reg_write_q <= 1'b0;
                alu_src_q   <= 1'b0;
            end
        end
    end

    assign Instr_out = instr_q;
    assign RegWrite  = reg_write_q;
    assign ALUSrc    = alu_src_q;

`ifdef ESM_FETCH_PERF_EN
    logic [31:0] bubble_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_q <= '0;
        end else if (!stall && !flush && fifo_empty && (bubble_q != 32'hFFFF_FFFF)) begin
            bubble_q <= bubble_q + 32'd1;
        end
    end

    assign bubble_cnt = bubble_q;
`endif

`ifndef SYNTHESIS
    // The credit rule must make a push into a full FIFO without a pop impossible.
    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && !flush && fifo_full && !fifo_pop));
`endif

endmodule

// File: tb/tb_esm_fetch_feeder.sv
// Randomized bench for esm_fetch_feeder against a queue-based reference model with
// an in-order variable-latency memory. Define ESM_FETCH_PERF_EN to check bubble_cnt.
module tb_esm_fetch_feeder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic [31:0] Instr_out;
    logic        RegWrite;
    logic        ALUSrc;
`ifdef ESM_FETCH_PERF_EN
    logic [31:0] bubble_cnt;
`endif

    always #5 clk = ~clk;

    esm_fetch_feeder #(
        .Instruction_word_size (32),
        .FIFO_DEPTH            (DEPTH),
        .ADDR_W                (32),
        .RESET_PC              (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .Instr_out  (Instr_out),
        .RegWrite   (RegWrite),
        .ALUSrc     (ALUSrc)
`ifdef ESM_FETCH_PERF_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Memory: word table plus in-order pending requests with due cycles
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic [31:0] mem [logic [31:0]];
    pend_t       pend [$];
    int          cyc = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          mem_on = 1'b1;
    int          n_req = 0;
    logic [31:0] last_req_addr = '0;

    // Reference model state
    logic [31:0] m_pc = '0;
    int          m_outst = 0;
    int          m_drop = 0;
    logic [31:0] m_fifo [$];
    logic [31:0] m_out = '0;
    logic        m_rw = 1'b0;
    logic        m_as = 1'b0;
    logic [31:0] m_bub = '0;

    function automatic logic [1:0] ref_flags(input logic [31:0] w);
        logic [6:0] op;
        logic [1:0] f;
        op = w[6:0];
        f[1] = op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67};
        f[0] = op inside {7'h13, 7'h03, 7'h23, 7'h67, 7'h37, 7'h17};
        return f;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 11))
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h23;
            4: w[6:0] = 7'h37;
            5: w[6:0] = 7'h17;
            6: w[6:0] = 7'h6F;
            7: w[6:0] = 7'h67;
            8: w[6:0] = 7'h63;
            9: w[6:0] = 7'h73;
            10: w = 32'h0;
            default: w[6:0] = 7'h0F;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = rand_word();
        return mem[a];
    endfunction

    function automatic void model_reset();
        m_pc = '0;
        m_outst = 0;
        m_drop = 0;
        m_fifo.delete();
        m_out = '0;
        m_rw = 1'b0;
        m_as = 1'b0;
        m_bub = '0;
        pend.delete();
        last_due = cyc;
    endfunction

    // One clock cycle; caller has set stall/flush/flush_pc at posedge+1
    task automatic cycle();
        bit          exp_req;
        bit          resp;
        logic [31:0] w;
        logic [1:0]  f;
        int          due;
        if (mem_on && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_valid = 1'b1;
            imem_rdata = mem_word(pend[0].addr);
        end else begin
            imem_valid = 1'b0;
            imem_rdata = $urandom();
        end
        @(negedge clk);
        exp_req = !flush && (m_fifo.size() + m_outst < DEPTH);
        check_eq("imem_req", imem_req, exp_req);
        if (exp_req) check_eq("imem_addr", imem_addr, m_pc);
        resp = imem_valid;
        if (imem_valid) void'(pend.pop_front());
        if (imem_req) begin
            n_req++;
            last_req_addr = imem_addr;
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due < last_due) due = last_due;
            last_due = due;
            pend.push_back('{addr: imem_addr, due: due});
        end
        if (flush) begin
            m_fifo.delete();
            m_out = '0;
            m_rw = 1'b0;
            m_as = 1'b0;
            m_pc = flush_pc;
            m_outst = m_outst - (resp ? 1 : 0);
            m_drop = m_outst;
        end else begin
            if (exp_req) m_pc = m_pc + 32'd4;
            m_outst = m_outst + (exp_req ? 1 : 0) - (resp ? 1 : 0);
            if (!stall) begin
                if (m_fifo.size() > 0) begin
                    w = m_fifo.pop_front();
                    f = ref_flags(w);
                    m_out = w;
                    m_rw = f[1];
                    m_as = f[0];
                end else begin
                    m_out = '0;
                    m_rw = 1'b0;
                    m_as = 1'b0;
                    if (m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 32'd1;
                end
            end
            if (resp) begin
                if (m_drop > 0) m_drop--;
                else m_fifo.push_back(imem_rdata);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check_eq("Instr_out", Instr_out, m_out);
        check_eq("RegWrite", RegWrite, m_rw);
        check_eq("ALUSrc", ALUSrc, m_as);
`ifdef ESM_FETCH_PERF_EN
        check_eq("bubble_cnt", bubble_cnt, m_bub);
`endif
    endtask

    // Asserts rst mid-cycle (no unmodelled clock edge) and checks async clearing
    task automatic apply_reset();
        imem_valid = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_Instr_out", Instr_out, 32'h0);
        check_eq("rst_RegWrite", RegWrite, 1'b0);
        check_eq("rst_ALUSrc", ALUSrc, 1'b0);
        check_eq("rst_imem_req", imem_req, 1'b0);
`ifdef ESM_FETCH_PERF_EN
        check_eq("rst_bubble_cnt", bubble_cnt, 32'h0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] first_word;
        @(posedge clk);
        #1;
        apply_reset();

        // Three immediate-latency fetches shown in order with decoded flags
        mem.delete();
        mem[32'h0] = 32'h00500093;
        mem[32'h4] = 32'h00A00113;
        mem[32'h8] = 32'h002081B3;
        repeat (3) cycle();
        check_eq("t1_w0", {Instr_out, RegWrite, ALUSrc}, {32'h00500093, 2'b11});
        cycle();
        check_eq("t1_w1", {Instr_out, RegWrite, ALUSrc}, {32'h00A00113, 2'b11});
        cycle();
        check_eq("t1_w2", {Instr_out, RegWrite, ALUSrc}, {32'h002081B3, 2'b10});

        // Silent memory: credit runs out after DEPTH requests
        apply_reset();
        mem_on = 1'b0;
        n_req = 0;
        repeat (10) cycle();
        check_eq("t2_credit_reqs", n_req, DEPTH);
        mem_on = 1'b1;

        // Fill under stall, hold, then drain without loss
        apply_reset();
        mem.delete();
        stall = 1'b1;
        repeat (9) cycle();
        check_eq("t3_full_no_req", imem_req, 1'b0);
        check_eq("t3_hold", Instr_out, 32'h0);
        stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cycle();
            check_eq("t3_drain", Instr_out, mem_word(32'(4 * i)));
        end
        repeat (6) cycle();

        // Flush with three requests in flight
        apply_reset();
        mem.delete();
        mem[32'h100] = 32'h00100093;
        lat_min = 6;
        lat_max = 6;
        repeat (3) cycle();
        flush = 1'b1;
        flush_pc = 32'h100;
        cycle();
        flush = 1'b0;
        check_eq("t4_flush_bubble", Instr_out, 32'h0);
        n_req = 0;
        cycle();
        check_eq("t4_redirect_req", n_req, 1);
        check_eq("t4_redirect_addr", last_req_addr, 32'h100);
        first_word = '0;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (first_word == 32'h0 && Instr_out != 32'h0) first_word = Instr_out;
        end
        check_eq("t4_first_after_flush", first_word, 32'h00100093);
        lat_min = 1;
        lat_max = 1;

        // Store then an all-zero word
        apply_reset();
        mem.delete();
        mem[32'h0] = 32'h0020A023;
        mem[32'h4] = 32'h0;
        repeat (3) cycle();
        check_eq("t5_store", {Instr_out, RegWrite, ALUSrc}, {32'h0020A023, 2'b01});
        cycle();
        check_eq("t5_zero", {Instr_out, RegWrite, ALUSrc}, {32'h0, 2'b00});

        // Randomized traffic with mid-stream resets
        mem.delete();
        for (int i = 0; i < 2000; i++) begin
            if (i % 250 == 0) begin
                lat_min = 1;
                lat_max = $urandom_range(1, 5);
            end
            if ($urandom_range(0, 299) == 0) begin
                apply_reset();
                n_req = 0;
                cycle();
                check_eq("rst_first_req", n_req, 1);
                check_eq("rst_first_addr", last_req_addr, 32'h0);
            end
            stall = ($urandom_range(0, 99) < 30);
            flush = ($urandom_range(0, 99) < 4);
            flush_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            cycle();
        end

        // Mid-stream reset in the middle of random traffic
        stall = 1'b0;
        flush = 1'b0;
        repeat (5) cycle();
        apply_reset();
        n_req = 0;
        cycle();
        check_eq("t6_first_req", n_req, 1);
        check_eq("t6_first_addr", last_req_addr, 32'h0);
        repeat (8) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
